// File: rtl/bky_unload_fsm.sv
// bky_unload_fsm -- Buckeye chain readback sequencer.
// Shifts the configuration chain out through SDI (MSB first), packs WORD_W
// bits per word and writes NWORDS words into the readback FIFO. It waits at
// word boundaries while the FIFO reports FULL.
// All registers update on the falling edge of CLK. RST is asynchronous and
// active-high.
// Optional build macro BKY_UNLOAD_TMR_EN triplicates every register and
// majority-votes the copies. Each copy is reloaded from the voted value, so a
// single upset copy is scrubbed on the next edge.
module bky_unload_fsm #(
   parameter int WORD_W = 16,
   parameter int NWORDS = 18
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic              SDI,
   input  logic              FULL,
   output logic              SHFT_ENA,
   output logic              WRENA,
   output logic [WORD_W-1:0] DOUT,
   output logic              DONE
);

   localparam int BCNT_W = $clog2(WORD_W);
   localparam int WCNT_W = $clog2(NWORDS + 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT     = 3'd1,
      S_SHIFT    = 3'd2,
      S_WRITE    = 3'd3,
      S_SET_DONE = 3'd4
   } state_t;

   // Complete register set of the block. Outputs are registered copies that
   // are decoded from the next state, so no output is glitch-prone.
   typedef struct packed {
      state_t              state;
      logic [BCNT_W-1:0]   bcnt;
      logic [WCNT_W-1:0]   wcnt;
      logic [WORD_W-1:0]   sreg;
      logic [WORD_W-1:0]   dout;
      logic                shft_ena;
      logic                wrena;
      logic                done;
   } regs_t;

   regs_t cur;   // current (voted, when triplicated) register value
   regs_t nxt;   // next register value

   // Next-state and next-output computation from the current register set
   always_comb begin
      nxt          = cur;
      nxt.shft_ena = 1'b0;
      nxt.wrena    = 1'b0;
      nxt.done     = 1'b0;
      case (cur.state)
         S_IDLE: begin
            nxt.bcnt = '0;
            nxt.wcnt = '0;
            if (START) begin
               nxt.state = FULL ? S_WAIT : S_SHIFT;
            end
         end
         S_WAIT: begin
            if (!FULL) begin
               nxt.state = S_SHIFT;
            end
         end
         S_SHIFT: begin
            nxt.sreg = {cur.sreg[WORD_W-2:0], SDI};
            if (cur.bcnt == BCNT_W'(WORD_W - 1)) begin
               // Last bit of the word: publish it and go write it out.
               nxt.dout  = {cur.sreg[WORD_W-2:0], SDI};
               nxt.bcnt  = '0;
               nxt.wcnt  = cur.wcnt + WCNT_W'(1);
               nxt.state = S_WRITE;
            end else begin
               nxt.bcnt = cur.bcnt + BCNT_W'(1);
            end
         end
         S_WRITE: begin
            if (cur.wcnt == WCNT_W'(NWORDS)) begin
               nxt.state = S_SET_DONE;
            end else if (FULL) begin
               nxt.state = S_WAIT;
            end else begin
               nxt.state = S_SHIFT;
            end
         end
         S_SET_DONE: begin
            if (!START) begin
               nxt.state = S_IDLE;
            end
         end
         default: begin
            nxt.state = S_IDLE;
         end
      endcase
      nxt.shft_ena = (nxt.state == S_SHIFT);
      nxt.wrena    = (nxt.state == S_WRITE);
      nxt.done     = (nxt.state == S_SET_DONE);
   end

`ifdef BKY_UNLOAD_TMR_EN
   (* keep = "true", preserve = "true" *) regs_t copy_a;
   (* keep = "true", preserve = "true" *) regs_t copy_b;
   (* keep = "true", preserve = "true" *) regs_t copy_c;
   (* keep = "true", preserve = "true" *) logic [$bits(regs_t)-1:0] voted;

   // Three register copies, each reloaded from the voted next value
   always_ff @(negedge CLK or posedge RST) begin
      if (RST) begin
         copy_a <= '0;
         copy_b <= '0;
         copy_c <= '0;
      end else begin
         copy_a <= nxt;
         copy_b <= nxt;
         copy_c <= nxt;
      end
   end

   // Bitwise majority of the three copies drives both logic and outputs
   always_comb begin
      voted = (copy_a & copy_b) | (copy_a & copy_c) | (copy_b & copy_c);
      cur   = regs_t'(voted);
   end
`else
   regs_t regs;

   // Single register copy
   always_ff @(negedge CLK or posedge RST) begin
      if (RST) begin
         regs <= '0;
      end else begin
         regs <= nxt;
      end
   end

   assign cur = regs;
`endif

   assign SHFT_ENA = cur.shft_ena;
   assign WRENA    = cur.wrena;
   assign DONE     = cur.done;
   assign DOUT     = cur.dout;

endmodule

// File: tb/tb_bky_unload_fsm.sv
// Directed bench for bky_unload_fsm at default parameters (16-bit words,
// 18 words). The DUT acts on falling edges; the bench drives and samples 1 ns
// after each falling edge.
module tb_bky_unload_fsm;

   logic        CLK = 1'b0;
   logic        RST;
   logic        START;
   logic        SDI;
   logic        FULL;
   logic        SHFT_ENA;
   logic        WRENA;
   logic [15:0] DOUT;
   logic        DONE;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] last_word;

   bky_unload_fsm #(.WORD_W(16), .NWORDS(18)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .START    (START),
      .SDI      (SDI),
      .FULL     (FULL),
      .SHFT_ENA (SHFT_ENA),
      .WRENA    (WRENA),
      .DOUT     (DOUT),
      .DONE     (DONE)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] word_of(input int k, input int seed);
      logic [15:0] kk;
      kk = 16'(k);
      if (seed == 0) return kk;
      return (kk * 16'h1357) ^ 16'hA5C3;
   endfunction

   // Called with the DUT in Shift. Feeds one word MSB first and checks the
   // write cycle that follows the 16th shifted bit.
   task automatic shift_word(input logic [15:0] w, input bit raise_full);
      for (int i = 15; i >= 0; i--) begin
         chk("shft_ena_hi", {31'd0, SHFT_ENA}, 32'd1);
         chk("wrena_lo", {31'd0, WRENA}, 32'd0);
         chk("done_lo", {31'd0, DONE}, 32'd0);
         chk("dout_hold", {16'd0, DOUT}, {16'd0, last_word});
         SDI = w[i];
         if (raise_full && i == 8) FULL = 1'b1;
         tick();
      end
      chk("wrena_hi", {31'd0, WRENA}, 32'd1);
      chk("shft_ena_wr", {31'd0, SHFT_ENA}, 32'd0);
      chk("done_wr", {31'd0, DONE}, 32'd0);
      chk("dout_word", {16'd0, DOUT}, {16'd0, w});
      last_word = w;
   endtask

   // Full 18-word readback starting with the DUT in Shift; ends on the cycle
   // DONE first rises.
   task automatic run_words(input int seed, input int full_word, input int hold);
      for (int k = 1; k <= 18; k++) begin
         shift_word(word_of(k, seed), (k == full_word));
`ifdef BKY_UNLOAD_TMR_EN
         if (k == 5 && full_word == 0 && seed == 0) begin
            force dut.copy_b.state = 3'd7;
            force dut.copy_c.wcnt = 5'h1F;
            #1;
            release dut.copy_b.state;
            release dut.copy_c.wcnt;
            #1;
            chk("tmr_wrena", {31'd0, WRENA}, 32'd1);
            chk("tmr_shft", {31'd0, SHFT_ENA}, 32'd0);
            chk("tmr_dout", {16'd0, DOUT}, {16'd0, word_of(5, 0)});
         end
`endif
         tick();
`ifdef BKY_UNLOAD_TMR_EN
         if (k == 5 && full_word == 0 && seed == 0) begin
            chk("tmr_b_conv", 32'(dut.copy_b.state), 32'(dut.copy_a.state));
            chk("tmr_c_conv", 32'(dut.copy_c.wcnt), 32'(dut.copy_a.wcnt));
         end
`endif
         if (k == 18) begin
            chk("done_rise", {31'd0, DONE}, 32'd1);
            chk("shft_ena_done", {31'd0, SHFT_ENA}, 32'd0);
            chk("wrena_done", {31'd0, WRENA}, 32'd0);
         end else if (k == full_word) begin
            for (int j = 0; j < hold; j++) begin
               chk("wait_shft", {31'd0, SHFT_ENA}, 32'd0);
               chk("wait_wrena", {31'd0, WRENA}, 32'd0);
               tick();
            end
            FULL = 1'b0;
            tick();
         end
      end
   endtask

   initial begin
      RST       = 1'b1;
      START     = 1'b0;
      SDI       = 1'b0;
      FULL      = 1'b0;
      last_word = 16'd0;
      #2;
      chk("rst_shft", {31'd0, SHFT_ENA}, 32'd0);
      chk("rst_wrena", {31'd0, WRENA}, 32'd0);
      chk("rst_done", {31'd0, DONE}, 32'd0);
      chk("rst_dout", {16'd0, DOUT}, 32'd0);
      tick();
      tick();
      RST = 1'b0;
      tick();
      chk("idle_shft", {31'd0, SHFT_ENA}, 32'd0);

      // Plain readback with START held high, then release
      START = 1'b1;
      tick();
      chk("start_lat", {31'd0, SHFT_ENA}, 32'd1);
      run_words(0, 0, 0);
      tick();
      chk("done_held", {31'd0, DONE}, 32'd1);
      chk("no_restart", {31'd0, SHFT_ENA}, 32'd0);
      START = 1'b0;
      tick();
      chk("done_clr", {31'd0, DONE}, 32'd0);
      chk("idle_after", {31'd0, SHFT_ENA}, 32'd0);

      // FULL high at START for 10 cycles
      START = 1'b1;
      FULL  = 1'b1;
      tick();
      for (int j = 0; j < 10; j++) begin
         chk("full_start", {31'd0, SHFT_ENA}, 32'd0);
         if (j == 9) FULL = 1'b0;
         tick();
      end
      run_words(1, 0, 0);
      START = 1'b0;
      tick();
      chk("done_clr2", {31'd0, DONE}, 32'd0);

      // FULL raised while word 5 is shifting
      START = 1'b1;
      tick();
      run_words(0, 5, 6);
      START = 1'b0;
      tick();
      chk("done_clr3", {31'd0, DONE}, 32'd0);

      // START pulsed for a single cycle
      START = 1'b1;
      tick();
      START = 1'b0;
      run_words(1, 0, 0);
      tick();
      chk("pulse_done_1cyc", {31'd0, DONE}, 32'd0);
      chk("pulse_idle", {31'd0, SHFT_ENA}, 32'd0);
      tick();
      chk("pulse_stay_idle", {31'd0, SHFT_ENA}, 32'd0);

      // Reset during word 9 after 7 bits
      START = 1'b1;
      tick();
      for (int k = 1; k <= 8; k++) begin
         shift_word(word_of(k, 0), 1'b0);
         tick();
      end
      for (int i = 15; i >= 9; i--) begin
         SDI = word_of(9, 0)[i];
         tick();
      end
      chk("pre_rst_shft", {31'd0, SHFT_ENA}, 32'd1);
      #2 RST = 1'b1;
      #1;
      chk("arst_shft", {31'd0, SHFT_ENA}, 32'd0);
      chk("arst_wrena", {31'd0, WRENA}, 32'd0);
      chk("arst_done", {31'd0, DONE}, 32'd0);
      chk("arst_dout", {16'd0, DOUT}, 32'd0);
      START     = 1'b0;
      last_word = 16'd0;
      tick();
      chk("rst_hold_wrena", {31'd0, WRENA}, 32'd0);
      chk("rst_hold_shft", {31'd0, SHFT_ENA}, 32'd0);
      RST = 1'b0;
      tick();
      chk("rst_idle", {31'd0, SHFT_ENA}, 32'd0);
      START = 1'b1;
      tick();
      chk("restart_lat", {31'd0, SHFT_ENA}, 32'd1);
      run_words(0, 0, 0);
      START = 1'b0;
      tick();
      chk("done_clr4", {31'd0, DONE}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bky_unload_fsm.md
Name: bky_unload_fsm

Overview:
- Readback counterpart of the Buckeye configuration loader.
- Drives the shift enable of the Buckeye serial chain and captures the returned serial bitstream MSB-first.
- Packs each WORD_W bits into one word and writes NWORDS words into the readback FIFO, honouring FIFO FULL back-pressure.
- Sits between the Buckeye chain output and the readback FIFO write port. It is started and completed by the same START/DONE handshake used by the loader.

Parameters:
- WORD_W, 16, bits per word shifted in from the chain.
- NWORDS, 18, words per complete readback.

Ports:
- CLK  input  1  system clock; all registers update on the falling edge.
- RST  input  1  reset, asynchronous, active-high.
- START  input  1  level request; a readback starts when START is high in Idle.
- SDI  input  1  serial data from the Buckeye chain; sampled on each falling edge while SHFT_ENA=1.
- FULL  input  1  readback FIFO full flag.
- SHFT_ENA  output  1  chain shift enable; high for exactly WORD_W consecutive cycles per word.
- WRENA  output  1  FIFO write enable; single-cycle pulse per word.
- DOUT  output  WORD_W  assembled word; valid while WRENA=1 and held until the next word.
- DONE  output  1  readback complete; held high while START stays high.

Behaviour:
- All outputs and state are registered and decoded from the registered state, so no combinational glitches. All registers update on the falling edge of CLK.
- Reset: state=Idle, SHFT_ENA=0, WRENA=0, DONE=0, DOUT=0, shift register=0, bcnt=0, wcnt=0. RST asserted mid-operation aborts immediately to these values; no partial word is written.
- Counters:
  - bcnt is the bit counter, width clog2(WORD_W).
  - wcnt is the word counter, width clog2(NWORDS+1), cleared on leaving Idle. No wrap is possible.
- States and transitions:
  - Idle: START=1 and FULL=0 -> Shift; START=1 and FULL=1 -> Wait4Space; otherwise stay. wcnt<=0, bcnt<=0.
  - Wait4Space: FULL=0 -> Shift, else stay. SHFT_ENA=0.
  - Shift: SHFT_ENA=1. Each edge does sreg<={sreg[WORD_W-2:0],SDI} and bcnt<=bcnt+1.
    - On the edge where bcnt==WORD_W-1: DOUT<={sreg[WORD_W-2:0],SDI}, bcnt<=0, wcnt<=wcnt+1, -> Write.
  - Write: WRENA=1 for one cycle. Next:
    - wcnt==NWORDS -> Set_Done;
    - else FULL=1 -> Wait4Space;
    - else -> Shift.
  - Set_Done: DONE=1. START=0 -> Idle, else stay.
- Illegal or unused state encodings -> Idle on the next edge.
- Latency with FULL low: START high at the edge to SHFT_ENA high is 1 cycle. One word takes WORD_W+1 cycles. DONE rises after NWORDS*(WORD_W+1) cycles in Shift/Write, i.e. 306 cycles at the defaults.
- FULL is examined only at word boundaries (Idle, Write, Wait4Space). A word once started is always shifted and written. The FIFO guarantees room for one word when FULL=0, since this block is the sole writer.
- START deasserted mid-readback is ignored; the transfer completes. If START is low on entry to Set_Done, DONE is high for exactly one cycle, then Idle.
- START held high in Set_Done does not restart. A new readback requires START low (return to Idle) then high.
- SHFT_ENA and WRENA are never high in the same cycle. DONE is never high with either.

Optional Feature:
- Macro BKY_UNLOAD_TMR_EN.
- When defined:
  - State, bcnt, wcnt, sreg, DOUT and the SHFT_ENA/WRENA/DONE registers are triplicated.
  - Each copy computes its next value from the bitwise majority vote of all three copies.
  - Outputs are the majority vote of the three copies, so a single upset copy is corrected on the next edge with no output disturbance.
  - Triplicated registers and voter nets carry synthesis keep/preserve attributes.
- When undefined: single-copy registers. Cycle behaviour is otherwise identical.

Test Plan:
- Reset, START=1, FULL=0, SDI driven from 18 words 0x0001..0x0012 MSB-first -> 18 WRENA pulses, each preceded by 16 SHFT_ENA cycles; DOUT matches each word; DONE rises at cycle 306; START low -> Idle and DONE=0 one cycle later.
- FULL=1 at START, released after 10 cycles -> SHFT_ENA stays 0 for those 10 cycles, then the normal sequence runs.
- FULL asserted during word 5 shifting -> word 5 is still written; held in Wait4Space (no SHFT_ENA) until FULL=0; word 6 then correct.
- START pulsed 1 cycle only -> full 18-word readback completes, DONE high exactly 1 cycle, return to Idle.
- RST asserted during word 9, bit 7 -> all outputs 0 immediately, no WRENA; a subsequent START yields a correct full readback starting at word 1.
- With BKY_UNLOAD_TMR_EN: force state copy 2 to an illegal value and wcnt copy 3 to 0x1F mid-readback -> outputs and DOUT unchanged vs reference model; copies reconverge next edge.
